// File: rtl/regfile_port_sequencer.sv
// regfile_port_sequencer
// Requester-side controller for a single-port register file. It accepts read
// requests (decode) and write requests (writeback) over valid/ready, buffers
// writes in an in-order queue and arbitrates the shared port. Read data comes
// back one cycle after issue, with queued writes bypassed so reads always see
// the newest value.
module regfile_port_sequencer #(
  parameter int REG_ADDRESS_SIZE = 2,
  parameter int MEM_WORD_SIZE    = 64,
  parameter int WQ_DEPTH         = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rdReqValid,
  output logic                              rdReqReady,
  input  logic [REG_ADDRESS_SIZE-1:0]       rdSelA,
  input  logic [REG_ADDRESS_SIZE-1:0]       rdSelB,
  output logic                              rdRespValid,
  output logic [MEM_WORD_SIZE-1:0]          rdDataA,
  output logic [MEM_WORD_SIZE-1:0]          rdDataB,
  input  logic                              wrReqValid,
  output logic                              wrReqReady,
  input  logic [REG_ADDRESS_SIZE-1:0]       wrSel,
  input  logic [MEM_WORD_SIZE-1:0]          wrData,
  output logic [REG_ADDRESS_SIZE-1:0]       rfSelA,
  output logic [REG_ADDRESS_SIZE-1:0]       rfSelB,
  output logic [REG_ADDRESS_SIZE-1:0]       rfSelWrite,
  output logic [MEM_WORD_SIZE-1:0]          rfWriteIn,
  output logic                              rfIsReading,
  input  logic [MEM_WORD_SIZE-1:0]          rfOutA,
  input  logic [MEM_WORD_SIZE-1:0]          rfOutB,
  output logic [$clog2(WQ_DEPTH+1)-1:0]     wqCount,
  output logic                              idle
);

  localparam int CW = $clog2(WQ_DEPTH + 1);
  localparam int PW = $clog2(WQ_DEPTH);

  // Write queue storage and bookkeeping
  logic [REG_ADDRESS_SIZE-1:0] r_wqAddr [WQ_DEPTH];
  logic [MEM_WORD_SIZE-1:0]    r_wqData [WQ_DEPTH];
  logic [PW-1:0]               r_head;
  logic [PW-1:0]               r_tail;
  logic [CW-1:0]               r_count;

  // Pending response and registered bypass result
  logic                        r_respValid;
  logic                        r_hitA;
  logic                        r_hitB;
  logic [MEM_WORD_SIZE-1:0]    r_bypA;
  logic [MEM_WORD_SIZE-1:0]    r_bypB;
  logic [MEM_WORD_SIZE-1:0]    r_holdA;
  logic [MEM_WORD_SIZE-1:0]    r_holdB;

  logic                        w_full;
  logic                        w_empty;
  logic                        w_issue;
  logic                        w_drain;
  logic                        w_enq;
  logic                        w_hitA;
  logic                        w_hitB;
  logic [MEM_WORD_SIZE-1:0]    w_bypDataA;
  logic [MEM_WORD_SIZE-1:0]    w_bypDataB;

  assign w_full  = (r_count == CW'(WQ_DEPTH));
  assign w_empty = (r_count == '0);

  // Port arbitration: a full queue forces a drain, otherwise reads win over drains
  always_comb begin
    w_issue = rdReqValid && !w_full;
    w_drain = !w_empty && !w_issue;
    w_enq   = wrReqValid && !w_full;
  end

  // Drive the register file port and the handshake/status outputs
  always_comb begin
    rdReqReady  = w_issue;
    wrReqReady  = !w_full;
    rfIsReading = !w_drain;
    rfSelA      = w_issue ? rdSelA : '0;
    rfSelB      = w_issue ? rdSelB : '0;
    rfSelWrite  = w_empty ? '0 : r_wqAddr[r_head];
    rfWriteIn   = w_empty ? '0 : r_wqData[r_head];
    wqCount     = r_count;
    idle        = w_empty && !r_respValid;
    rdRespValid = r_respValid;
  end

  // Bypass search: walk queued entries oldest to youngest so the youngest match
  // wins, then let a write accepted on this same edge override everything
  always_comb begin
    w_hitA     = 1'b0;
    w_hitB     = 1'b0;
    w_bypDataA = '0;
    w_bypDataB = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        if (r_wqAddr[r_head + PW'(i)] == rdSelA) begin
          w_hitA     = 1'b1;
          w_bypDataA = r_wqData[r_head + PW'(i)];
        end
        if (r_wqAddr[r_head + PW'(i)] == rdSelB) begin
          w_hitB     = 1'b1;
          w_bypDataB = r_wqData[r_head + PW'(i)];
        end
      end
    end
    if (w_enq && (wrSel == rdSelA)) begin
      w_hitA     = 1'b1;
      w_bypDataA = wrData;
    end
    if (w_enq && (wrSel == rdSelB)) begin
      w_hitB     = 1'b1;
      w_bypDataB = wrData;
    end
  end

  // Response data: live during the response cycle, held afterwards
  always_comb begin
    rdDataA = r_holdA;
    rdDataB = r_holdB;
    if (r_respValid) begin
      rdDataA = r_hitA ? r_bypA : rfOutA;
      rdDataB = r_hitB ? r_bypB : rfOutB;
    end
  end

  // Queue payload storage; contents past the pointers are simply ignored
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_wqAddr[r_tail] <= wrSel;
      r_wqData[r_tail] <= wrData;
    end
  end

  // Queue pointers and occupancy; pushes and pops in the same cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture the read response flag and bypass result at the issue edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_respValid <= 1'b0;
      r_hitA      <= 1'b0;
      r_hitB      <= 1'b0;
      r_bypA      <= '0;
      r_bypB      <= '0;
    end else begin
      r_respValid <= w_issue;
      if (w_issue) begin
        r_hitA <= w_hitA;
        r_hitB <= w_hitB;
        r_bypA <= w_bypDataA;
        r_bypB <= w_bypDataB;
      end
    end
  end

  // Remember the last delivered response so the data outputs stay stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_holdA <= '0;
      r_holdB <= '0;
    end else if (r_respValid) begin
      r_holdA <= rdDataA;
      r_holdB <= rdDataB;
    end
  end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// tb_regfile_port_sequencer
// Drives directed and random read/write traffic into the sequencer, models the
// external register file, and compares every cycle against an architectural
// model: a per-register "newest value" array plus an in-order queue of
// accepted-but-uncommitted writes.
module tb_regfile_port_sequencer;

  localparam int AW    = 2;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          rdReqValid;
  logic          rdReqReady;
  logic [AW-1:0] rdSelA;
  logic [AW-1:0] rdSelB;
  logic          rdRespValid;
  logic [DW-1:0] rdDataA;
  logic [DW-1:0] rdDataB;
  logic          wrReqValid;
  logic          wrReqReady;
  logic [AW-1:0] wrSel;
  logic [DW-1:0] wrData;
  logic [AW-1:0] rfSelA;
  logic [AW-1:0] rfSelB;
  logic [AW-1:0] rfSelWrite;
  logic [DW-1:0] rfWriteIn;
  logic          rfIsReading;
  logic [DW-1:0] rfOutA;
  logic [DW-1:0] rfOutB;
  logic [CW-1:0] wqCount;
  logic          idle;

  int errorCount = 0;
  int checkCount = 0;

  logic          rfLoad;
  logic [DW-1:0] rfInit [4];
  logic [DW-1:0] rfRegs [4];
  logic [DW-1:0] latest [4];
  logic [AW-1:0] qAddr [$];
  logic [DW-1:0] qData [$];
  logic          expValid;
  logic [DW-1:0] expA;
  logic [DW-1:0] expB;
  logic [DW-1:0] heldA;
  logic [DW-1:0] heldB;
  logic [DW-1:0] savedReg0;

  regfile_port_sequencer #(
    .REG_ADDRESS_SIZE(AW),
    .MEM_WORD_SIZE(DW),
    .WQ_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rdReqValid(rdReqValid),
    .rdReqReady(rdReqReady),
    .rdSelA(rdSelA),
    .rdSelB(rdSelB),
    .rdRespValid(rdRespValid),
    .rdDataA(rdDataA),
    .rdDataB(rdDataB),
    .wrReqValid(wrReqValid),
    .wrReqReady(wrReqReady),
    .wrSel(wrSel),
    .wrData(wrData),
    .rfSelA(rfSelA),
    .rfSelB(rfSelB),
    .rfSelWrite(rfSelWrite),
    .rfWriteIn(rfWriteIn),
    .rfIsReading(rfIsReading),
    .rfOutA(rfOutA),
    .rfOutB(rfOutB),
    .wqCount(wqCount),
    .idle(idle)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External single-port register file: one read or one write per edge
  always @(posedge clk) begin
    if (rfLoad) begin
      for (int i = 0; i < 4; i++) rfRegs[i] <= rfInit[i];
      rfOutA <= '0;
      rfOutB <= '0;
    end else if (rfIsReading) begin
      rfOutA <= rfRegs[rfSelA];
      rfOutB <= rfRegs[rfSelB];
    end else begin
      rfRegs[rfSelWrite] <= rfWriteIn;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic applyStimulus(input logic rv, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                               input logic wv, input logic [AW-1:0] ws, input logic [DW-1:0] wd);
    int   size;
    logic full;
    logic issue;
    logic enq;
    logic drain;
    @(negedge clk);
    rdReqValid = rv;
    rdSelA     = sa;
    rdSelB     = sb;
    wrReqValid = wv;
    wrSel      = ws;
    wrData     = wd;
    #1;
    checkOutput("rdRespValid", 64'(rdRespValid), 64'(expValid));
    if (expValid) begin
      checkOutput("rdDataA", rdDataA, expA);
      checkOutput("rdDataB", rdDataB, expB);
      heldA = expA;
      heldB = expB;
    end else begin
      checkOutput("rdDataA hold", rdDataA, heldA);
      checkOutput("rdDataB hold", rdDataB, heldB);
    end
    size  = qAddr.size();
    full  = (size == DEPTH);
    issue = rv && !full;
    enq   = wv && !full;
    drain = (size > 0) && !issue;
    checkOutput("wqCount", 64'(wqCount), 64'(size));
    checkOutput("wrReqReady", 64'(wrReqReady), 64'(!full));
    checkOutput("rdReqReady", 64'(rdReqReady), 64'(issue));
    checkOutput("rfIsReading", 64'(rfIsReading), 64'(!drain));
    checkOutput("idle", 64'(idle), 64'((size == 0) && !expValid));
    if (size > 0) begin
      checkOutput("rfSelWrite", 64'(rfSelWrite), 64'(qAddr[0]));
      checkOutput("rfWriteIn", rfWriteIn, qData[0]);
    end else begin
      checkOutput("rfSelWrite zero", 64'(rfSelWrite), 64'(0));
      checkOutput("rfWriteIn zero", rfWriteIn, 64'(0));
    end
    if (issue) begin
      checkOutput("rfSelA", 64'(rfSelA), 64'(sa));
      checkOutput("rfSelB", 64'(rfSelB), 64'(sb));
    end else if (!drain) begin
      checkOutput("rfSelA nop", 64'(rfSelA), 64'(0));
      checkOutput("rfSelB nop", 64'(rfSelB), 64'(0));
    end
    if (drain) begin
      void'(qAddr.pop_front());
      void'(qData.pop_front());
    end
    if (enq) begin
      qAddr.push_back(ws);
      qData.push_back(wd);
      latest[ws] = wd;
    end
    expValid = issue;
    if (issue) begin
      expA = latest[sa];
      expB = latest[sb];
    end
    @(posedge clk);
  endtask

  // Assert reset asynchronously, check the cleared state, release and resync the model
  task automatic resetDut();
    @(negedge clk);
    rst_n      = 1'b0;
    rdReqValid = 1'b0;
    wrReqValid = 1'b0;
    rdSelA     = '0;
    rdSelB     = '0;
    wrSel      = '0;
    wrData     = '0;
    #1;
    checkOutput("reset rdRespValid", 64'(rdRespValid), 64'(0));
    checkOutput("reset wqCount", 64'(wqCount), 64'(0));
    checkOutput("reset rfIsReading", 64'(rfIsReading), 64'(1));
    checkOutput("reset rfSelA", 64'(rfSelA), 64'(0));
    checkOutput("reset rfSelB", 64'(rfSelB), 64'(0));
    checkOutput("reset rfSelWrite", 64'(rfSelWrite), 64'(0));
    checkOutput("reset idle", 64'(idle), 64'(1));
    checkOutput("reset rdDataA", rdDataA, 64'(0));
    checkOutput("reset rdDataB", rdDataB, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    qAddr.delete();
    qData.delete();
    expValid = 1'b0;
    heldA    = '0;
    heldB    = '0;
    for (int i = 0; i < 4; i++) latest[i] = rfRegs[i];
  endtask

  initial begin
    rst_n      = 1'b0;
    rfLoad     = 1'b1;
    rdReqValid = 1'b0;
    wrReqValid = 1'b0;
    rdSelA     = '0;
    rdSelB     = '0;
    wrSel      = '0;
    wrData     = '0;
    expValid   = 1'b0;
    expA       = '0;
    expB       = '0;
    heldA      = '0;
    heldB      = '0;
    for (int i = 0; i < 4; i++) rfInit[i] = {$urandom(), $urandom()};
    repeat (2) @(negedge clk);
    rfLoad = 1'b0;
    resetDut();

    $display("[TB] write then read");
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 2'd2, 64'hAA);
    #2;
    checkOutput("wr2 rfIsReading", 64'(rfIsReading), 64'(0));
    checkOutput("wr2 rfSelWrite", 64'(rfSelWrite), 64'(2));
    checkOutput("wr2 rfWriteIn", rfWriteIn, 64'hAA);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 64'h0);
    applyStimulus(1'b1, 2'd2, 2'd0, 1'b0, 2'd0, 64'h0);
    #2;
    checkOutput("rd2 rdRespValid", 64'(rdRespValid), 64'(1));
    checkOutput("rd2 rdDataA", rdDataA, 64'hAA);

    $display("[TB] bypass youngest");
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b1, 2'd1, 64'h11);
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b1, 2'd1, 64'h22);
    applyStimulus(1'b1, 2'd1, 2'd3, 1'b0, 2'd0, 64'h0);
    #2;
    checkOutput("byp rdDataA", rdDataA, 64'h22);
    checkOutput("byp rdDataB", rdDataB, rfInit[3]);

    $display("[TB] same-edge bypass");
    applyStimulus(1'b1, 2'd3, 2'd0, 1'b1, 2'd3, 64'h5);
    #2;
    checkOutput("same-edge rdDataA", rdDataA, 64'h5);

    $display("[TB] full queue");
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b1, 2'd2, 64'h77);
    #2;
    checkOutput("full wqCount", 64'(wqCount), 64'(4));
    checkOutput("full wrReqReady", 64'(wrReqReady), 64'(0));
    checkOutput("full rdReqReady", 64'(rdReqReady), 64'(0));
    checkOutput("full rfIsReading", 64'(rfIsReading), 64'(0));
    checkOutput("full head sel", 64'(rfSelWrite), 64'(1));
    checkOutput("full head data", rfWriteIn, 64'h11);
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 64'h0);
    #2;
    checkOutput("after drain wqCount", 64'(wqCount), 64'(3));
    checkOutput("after drain rdReqReady", 64'(rdReqReady), 64'(1));
    applyStimulus(1'b1, 2'd0, 2'd1, 1'b0, 2'd0, 64'h0);
    repeat (3) applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 64'h0);
    applyStimulus(1'b1, 2'd1, 2'd3, 1'b0, 2'd0, 64'h0);
    #2;
    checkOutput("committed reg1", rdDataA, 64'h22);
    checkOutput("committed reg3", rdDataB, 64'h5);
    applyStimulus(1'b1, 2'd2, 2'd0, 1'b0, 2'd0, 64'h0);
    #2;
    checkOutput("committed reg2", rdDataA, 64'h77);

    $display("[TB] reset mid-op");
    savedReg0 = latest[0];
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b1, 2'd0, 64'h99);
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b1, 2'd1, 64'h98);
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b1, 2'd2, 64'h97);
    #2;
    checkOutput("pre-reset wqCount", 64'(wqCount), 64'(3));
    resetDut();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 64'h0);
      #2;
      checkOutput("post-reset no write", 64'(rfIsReading), 64'(1));
    end
    applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 64'h0);
    #2;
    checkOutput("discarded write reg0", rdDataA, savedReg0);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      if (c == 250) resetDut();
      applyStimulus(($urandom_range(0, 99) < ((c < 200) ? 80 : 30)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 50),
                    2'($urandom_range(0, 3)), {$urandom(), $urandom()});
    end
    repeat (DEPTH + 1) applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 64'h0);
    for (int r = 0; r < 4; r++) applyStimulus(1'b1, 2'(r), 2'(3 - r), 1'b0, 2'd0, 64'h0);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 64'h0);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/regfile_port_sequencer.md
Name: regfile_port_sequencer

Overview:
- Requester-side controller that drives the single-port register file. The register file does either a read or a write per clk edge, selected by isReading.
- Accepts read requests from decode and write requests from writeback, each with a valid/ready handshake.
- Buffers writes in a small in-order queue and arbitrates the shared port.
- Returns read data one cycle after issue, bypassing queued (not yet committed) writes so reads always see the newest value.

Parameters:
- REG_ADDRESS_SIZE, 2, register select width (matches register file).
- MEM_WORD_SIZE, 64, data word width.
- WQ_DEPTH, 4, write-queue entries (power of two, >=2).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rdReqValid  in  1  read request present.
- rdReqReady  out  1  read accepted this cycle.
- rdSelA  in  REG_ADDRESS_SIZE  read address A.
- rdSelB  in  REG_ADDRESS_SIZE  read address B.
- rdRespValid  out  1  read data valid (1-cycle pulse).
- rdDataA  out  MEM_WORD_SIZE  result A.
- rdDataB  out  MEM_WORD_SIZE  result B.
- wrReqValid  in  1  write request present.
- wrReqReady  out  1  write accepted this cycle.
- wrSel  in  REG_ADDRESS_SIZE  write address.
- wrData  in  MEM_WORD_SIZE  write data.
- rfSelA  out  REG_ADDRESS_SIZE  to register file selA.
- rfSelB  out  REG_ADDRESS_SIZE  to register file selB.
- rfSelWrite  out  REG_ADDRESS_SIZE  to register file selWrite.
- rfWriteIn  out  MEM_WORD_SIZE  to register file writeIn.
- rfIsReading  out  1  to register file isReading.
- rfOutA  in  MEM_WORD_SIZE  from register file outA.
- rfOutB  in  MEM_WORD_SIZE  from register file outB.
- wqCount  out  $clog2(WQ_DEPTH+1)  queued write count.
- idle  out  1  queue empty and no response pending.

Behaviour:
- Interface: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset state:
  - Queue is empty; wqCount=0.
  - rdRespValid=0; rdDataA=rdDataB=0.
  - Pending-response and bypass registers are cleared.
  - Queued writes and any in-flight response are discarded, never committed or returned.
- Port arbitration is combinational each cycle, in this priority order:
  - (1) Queue full (wqCount==WQ_DEPTH): drain head. rfIsReading=0, rfSelWrite/rfWriteIn=head entry, rdReqReady=0.
  - (2) Otherwise, if rdReqValid: issue read. rfIsReading=1, rfSelA=rdSelA, rfSelB=rdSelB, rdReqReady=1.
  - (3) Otherwise, if queue non-empty: drain head, as in (1).
  - (4) Otherwise: NOP read. rfIsReading=1, rfSel*=0.
- rfSelWrite/rfWriteIn carry the head entry whenever the queue is non-empty, and 0 otherwise.
- Enqueue:
  - wrReqReady = (wqCount < WQ_DEPTH).
  - Write accepted at the edge when wrReqValid && wrReqReady.
  - Enqueue and dequeue may occur in the same cycle; wqCount is unchanged in that case.
  - Pointers wrap modulo WQ_DEPTH.
- Drain: the head pops at the edge where it is presented. Writes commit in acceptance order.
- Read latency:
  - A read issued at edge N gives rdRespValid=1 for the cycle after N only.
  - There is no response backpressure.
  - Back-to-back reads give a response every cycle.
- Bypass:
  - At the issue edge, for each of A and B, search all valid queue entries plus a write accepted that same edge (which counts as youngest).
  - The youngest entry with a matching address wins; its data and a hit flag are registered.
  - rdDataA/B = hit ? bypass data : rfOutA/B. rdDataA/B hold their value when rdRespValid=0.
- Reads never issue while the queue is full. Every committed write therefore precedes any later-issued read, and every uncommitted write is visible to bypass.
- Register 0 is an ordinary register (not hard-wired).
- Starvation bound: continuous reads delay writes only until the queue fills. A forced drain then stalls reads one cycle per entry until wqCount<WQ_DEPTH.
- idle = (wqCount==0) && !rdRespValid.

Test Plan:
- Reset: hold rst_n=0 mid-stream -> rdRespValid=0, wqCount=0, rfIsReading=1, rfSel*=0, idle=1.
- Write then read:
  - Write reg2=0xAA with no reads -> next cycle rfIsReading=0, rfSelWrite=2, rfWriteIn=0xAA.
  - Then read A=2 -> rdRespValid one cycle after issue, rdDataA=0xAA.
- Bypass youngest:
  - Hold rdReqValid=1 to block drains; enqueue reg1=0x11, then reg1=0x22.
  - Read A=1, B=3 -> rdDataA=0x22, rdDataB=RF value of reg3.
- Same-edge bypass: accept write reg3=0x5 on the same edge as read A=3 -> rdDataA=0x5.
- Full queue:
  - Reads held high, 4 writes enqueued -> wrReqReady=0, rdReqReady=0.
  - Head drains (rfIsReading=0), then reads resume once wqCount=3.
  - All 4 writes later commit in order.
- Reset mid-op: wqCount=3, then pulse rst_n low -> wqCount=0 and no rfIsReading=0 cycles after release without new writes.
